// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: port-select encoding,
// write-buffer entry layout and counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_IF   = 2'd1,
        SEL_DM   = 2'd2
    } sel_e;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_DRAIN = 2'd1,
        OP_IF    = 2'd2,
        OP_DM    = 2'd3
    } op_e;

    localparam int CONFLICT_W = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // Entry layout at default widths; the buffer stores the same fields flat,
    // MSB first: {addr, wdata, eh, eb}.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic                  eh;
        logic                  eb;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

    function automatic int wb_entry_w(input int aw, input int dw);
        return aw + dw + 2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU fetch/data ports plus memory-macro side of the unified-memory arbiter.
// master = CPU datapath and memory model, slave = arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_eh;
    logic                  dm_eb;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [DATA_W-1:0]     dm_rdata;

    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_we;
    logic                  mem_eh;
    logic                  mem_eb;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  wb_empty;
    logic [CONFLICT_W-1:0] conflict_cnt;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_eh, dm_eb, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_addr, mem_wdata, mem_we, mem_eh, mem_eb, wb_empty, conflict_cnt
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_eh, dm_eb, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_addr, mem_wdata, mem_we, mem_eh, mem_eb, wb_empty, conflict_cnt
    );

endinterface

// File: rtl/mem_port_arbiter_wr_buffer.sv
// Posted-store FIFO: DEPTH entries of {addr, wdata, eh, eb} with a per-entry
// address-match vector used for the load-after-store hazard check.
module wr_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 10,
    parameter int EW    = 44
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [EW-1:0]    push_entry,
    input  logic             pop,
    input  logic [AW-1:0]    match_addr,
    output logic             full,
    output logic             empty,
    output logic [EW-1:0]    head,
    output logic [DEPTH-1:0] match
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][EW-1:0] ent_q;
    logic [DEPTH-1:0]         vld_q;
    logic [PW-1:0]            wptr_q, rptr_q;

    assign full  = &vld_q;
    assign empty = ~|vld_q;
    assign head  = ent_q[rptr_q];

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match[i] = vld_q[i] && (ent_q[i][EW-1 -: AW] == match_addr);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (pop && !empty) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= rptr_q + 1'b1;
            end
            if (push && !full) begin
                vld_q[wptr_q] <= 1'b1;
                ent_q[wptr_q] <= push_entry;
                wptr_q        <= wptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between fetch and data ports: posted
// stores, round-robin read arbitration, hazard/full-driven drains.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int EW = wb_entry_w(ADDR_W, DATA_W);

    logic                  wb_full, wb_empty_i, push, pop;
    logic [EW-1:0]         head;
    logic [WB_DEPTH-1:0]   match;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_wdata;
    logic                  head_eh, head_eb;

    op_e                   op;
    sel_e                  sel_q, sel_d;
    logic                  last_tie_q, last_tie_d;
    logic                  load_pend, store_req, hazard, tie, conflict;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q, if_rdata_q, dm_rdata_q;
    logic [CONFLICT_W-1:0] conflict_q;

    assign {head_addr, head_wdata, head_eh, head_eb} = head;

    assign load_pend = bus.dm_req && !bus.dm_we;
    assign store_req = bus.dm_req && bus.dm_we && !reset;
    assign hazard    = load_pend && (|match);
    assign push      = store_req && !wb_full;
    assign pop       = (op == OP_DRAIN);

    wr_buffer #(.DEPTH(WB_DEPTH), .AW(ADDR_W), .EW(EW)) u_wb (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry ({bus.dm_addr, bus.dm_wdata, bus.dm_eh, bus.dm_eb}),
        .pop        (pop),
        .match_addr (bus.dm_addr),
        .full       (wb_full),
        .empty      (wb_empty_i),
        .head       (head),
        .match      (match)
    );

    // Port selection; last_tie_q = 1 means fetch won the previous tie.
    always_comb begin
        op  = OP_IDLE;
        tie = 1'b0;
        if (!reset) begin
            if (wb_full || hazard) begin
                op = OP_DRAIN;
            end else if (bus.if_req && load_pend) begin
                tie = 1'b1;
                op  = last_tie_q ? OP_DM : OP_IF;
            end else if (bus.if_req) begin
                op = OP_IF;
            end else if (load_pend) begin
                op = OP_DM;
            end else if (!wb_empty_i) begin
                op = OP_DRAIN;
            end
        end
    end

    always_comb begin
        bus.if_gnt    = (op == OP_IF);
        bus.dm_gnt    = push || (op == OP_DM);
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_we    = 1'b0;
        bus.mem_eh    = 1'b0;
        bus.mem_eb    = 1'b0;
        sel_d         = SEL_NONE;
        last_tie_d    = last_tie_q;
        unique case (op)
            OP_DRAIN: begin
                bus.mem_addr  = head_addr;
                bus.mem_wdata = head_wdata;
                bus.mem_we    = 1'b1;
                bus.mem_eh    = head_eh;
                bus.mem_eb    = head_eb;
            end
            OP_IF: begin
                bus.mem_addr = bus.if_addr;
                sel_d        = SEL_IF;
            end
            OP_DM: begin
                bus.mem_addr = bus.dm_addr;
                sel_d        = SEL_DM;
            end
            default: ;
        endcase
        if (tie) last_tie_d = (op == OP_IF);
    end

    assign conflict = (bus.if_req && (op != OP_IF)) || (load_pend && (op != OP_DM));

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q      <= SEL_NONE;
            last_tie_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            conflict_q <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            sel_q      <= sel_d;
            last_tie_q <= last_tie_d;
            addr_q     <= bus.mem_addr;
            wdata_q    <= bus.mem_wdata;
            if (conflict && (conflict_q != {CONFLICT_W{1'b1}}))
                conflict_q <= conflict_q + 1'b1;
            if (sel_q == SEL_IF) if_rdata_q <= bus.mem_rdata;
            if (sel_q == SEL_DM) dm_rdata_q <= bus.mem_rdata;
        end
    end

    // Memory data lands the cycle after the grant; the idle port keeps its last word.
    assign bus.if_rvalid    = !reset && (sel_q == SEL_IF);
    assign bus.dm_rvalid    = !reset && (sel_q == SEL_DM);
    assign bus.if_rdata     = bus.if_rvalid ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_rdata     = bus.dm_rvalid ? bus.mem_rdata : dm_rdata_q;
    assign bus.wb_empty     = wb_empty_i;
    assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous-read memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .WB_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: write and read issued in the same cycle, data next cycle.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
        mem[10'h004] = 32'h8C22_0000;
        mem[10'h040] = 32'hDEAD_0040;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs after the falling edge, settle, then checks follow.
    task automatic drive(input logic rst, input logic ifr, input logic [9:0] ifa,
                         input logic dr, input logic dwe, input logic [9:0] da,
                         input logic [31:0] dd, input logic eh, input logic eb);
        @(negedge clk);
        reset        = rst;
        bus.if_req   = ifr;
        bus.if_addr  = ifa;
        bus.dm_req   = dr;
        bus.dm_we    = dwe;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        bus.dm_eh    = eh;
        bus.dm_eb    = eb;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_eh = 0; bus.dm_eb = 0;

        // reset values
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_if_gnt", bus.if_gnt, 0);
        chk("rst_dm_gnt", bus.dm_gnt, 0);
        chk("rst_if_rvalid", bus.if_rvalid, 0);
        chk("rst_dm_rvalid", bus.dm_rvalid, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_eh_eb", {bus.mem_eh, bus.mem_eb}, 0);
        chk("rst_wb_empty", bus.wb_empty, 1);
        chk("rst_conflict", bus.conflict_cnt, 0);

        // single fetch
        drive(0, 1, 10'h004, 0, 0, 0, 0, 0, 0);
        chk("f1_if_gnt", bus.if_gnt, 1);
        chk("f1_mem_addr", bus.mem_addr, 10'h004);
        chk("f1_mem_we", bus.mem_we, 0);
        chk("f1_dm_gnt", bus.dm_gnt, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("f1_if_rvalid", bus.if_rvalid, 1);
        chk("f1_if_rdata", bus.if_rdata, 32'h8C22_0000);
        chk("f1_dm_rvalid", bus.dm_rvalid, 0);
        chk("f1_idle_addr_hold", bus.mem_addr, 10'h004);

        // fetch and load tie for 4 cycles: IF, DM, IF, DM
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 10'h008, 1, 0, 10'h020, 0, 0, 0);
            chk("tie_if_gnt", bus.if_gnt, (k % 2) == 0);
            chk("tie_dm_gnt", bus.dm_gnt, (k % 2) == 1);
            if (k == 1) chk("tie_if_rdata", bus.if_rdata, 32'hA500_0008);
            if (k == 2) chk("tie_dm_rdata", bus.dm_rdata, 32'hA500_0020);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("tie_last_dm_rvalid", bus.dm_rvalid, 1);
        chk("tie_conflict", bus.conflict_cnt, 4);

        // store then load same address: one-cycle stall while draining
        drive(0, 0, 0, 1, 1, 10'h010, 32'h0000_BEEF, 0, 0);
        chk("raw_st_gnt", bus.dm_gnt, 1);
        chk("raw_st_no_we", bus.mem_we, 0);
        drive(0, 0, 0, 1, 0, 10'h010, 0, 0, 0);
        chk("raw_ld_stall", bus.dm_gnt, 0);
        chk("raw_drain_we", bus.mem_we, 1);
        chk("raw_drain_addr", bus.mem_addr, 10'h010);
        chk("raw_drain_wdata", bus.mem_wdata, 32'h0000_BEEF);
        drive(0, 0, 0, 1, 0, 10'h010, 0, 0, 0);
        chk("raw_ld_gnt", bus.dm_gnt, 1);
        chk("raw_ld_addr", bus.mem_addr, 10'h010);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_rvalid", bus.dm_rvalid, 1);
        chk("raw_rdata", bus.dm_rdata, 32'h0000_BEEF);
        chk("raw_if_rdata_hold", bus.if_rdata, 32'hA500_0008);
        chk("raw_conflict", bus.conflict_cnt, 5);

        // three stores against continuous fetch
        drive(0, 1, 10'h00C, 1, 1, 10'h100, 32'h1111_1111, 0, 0);
        chk("wb_st1_gnt", bus.dm_gnt, 1);
        chk("wb_st1_if_gnt", bus.if_gnt, 1);
        drive(0, 1, 10'h00C, 1, 1, 10'h101, 32'h2222_2222, 0, 0);
        chk("wb_st2_gnt", bus.dm_gnt, 1);
        chk("wb_st2_if_gnt", bus.if_gnt, 1);
        chk("wb_st2_if_rdata", bus.if_rdata, 32'hA500_000C);
        drive(0, 1, 10'h00C, 1, 1, 10'h102, 32'h3333_3333, 0, 0);
        chk("wb_full_st3_gnt", bus.dm_gnt, 0);
        chk("wb_full_if_gnt", bus.if_gnt, 0);
        chk("wb_full_drain_we", bus.mem_we, 1);
        chk("wb_full_drain_addr", bus.mem_addr, 10'h100);
        drive(0, 1, 10'h00C, 1, 1, 10'h102, 32'h3333_3333, 0, 0);
        chk("wb_st3_retry_gnt", bus.dm_gnt, 1);
        chk("wb_st3_if_gnt", bus.if_gnt, 1);
        chk("wb_no_rvalid_after_drain", bus.if_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wb_drain_b_addr", bus.mem_addr, 10'h101);
        chk("wb_drain_b_wdata", bus.mem_wdata, 32'h2222_2222);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wb_drain_c_addr", bus.mem_addr, 10'h102);
        chk("wb_drain_c_wdata", bus.mem_wdata, 32'h3333_3333);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wb_empty_after", bus.wb_empty, 1);
        chk("wb_idle_we", bus.mem_we, 0);
        chk("wb_idle_addr_hold", bus.mem_addr, 10'h102);

        // halfword-enable store drains with eh passed through
        drive(0, 0, 0, 1, 1, 10'h030, 32'h0000_ABCD, 1, 0);
        chk("en_st_gnt", bus.dm_gnt, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("en_drain_we", bus.mem_we, 1);
        chk("en_drain_eh_eb", {bus.mem_eh, bus.mem_eb}, 2'b10);
        chk("en_drain_addr", bus.mem_addr, 10'h030);
        drive(0, 0, 0, 1, 0, 10'h030, 0, 0, 0);
        chk("en_we_pulse_end", bus.mem_we, 0);
        chk("en_eh_cleared", bus.mem_eh, 0);
        chk("en_ld_gnt", bus.dm_gnt, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("en_ld_rdata", bus.dm_rdata, 32'h0000_ABCD);
        chk("en_conflict", bus.conflict_cnt, 6);

        // reset with two buffered stores and a read in flight
        drive(0, 1, 10'h00C, 1, 1, 10'h040, 32'h0000_0055, 0, 0);
        chk("mr_st1_gnt", bus.dm_gnt, 1);
        drive(0, 1, 10'h00C, 1, 1, 10'h041, 32'h0000_0066, 0, 0);
        chk("mr_st2_gnt", bus.dm_gnt, 1);
        chk("mr_not_empty", bus.wb_empty, 0);
        drive(1, 1, 10'h00C, 0, 0, 0, 0, 0, 0);
        chk("mr_rst_rvalid", bus.if_rvalid, 0);
        chk("mr_rst_if_gnt", bus.if_gnt, 0);
        chk("mr_rst_we", bus.mem_we, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_wb_empty", bus.wb_empty, 1);
        chk("mr_no_we", bus.mem_we, 0);
        chk("mr_no_rvalid", bus.if_rvalid, 0);
        chk("mr_conflict", bus.conflict_cnt, 0);
        chk("mr_addr", bus.mem_addr, 0);
        drive(0, 0, 0, 1, 0, 10'h040, 0, 0, 0);
        chk("mr_ld_gnt", bus.dm_gnt, 1);
        chk("mr_ld_no_we", bus.mem_we, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_discarded_store", bus.dm_rdata, 32'hDEAD_0040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
